// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit 1, N data bits MSB first, optional even parity, stop bit 0.
// Optional parity stage is enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         si,
  input  logic         rd,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         busy,
  output logic         ovf,
  output logic         ferr,
  output logic         perr
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StStop = 2'd2
`ifdef SERIAL_FRAME_RX_PARITY_EN
    ,
    StPar  = 2'd3
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [N-1:0]    q_d;
  logic            valid_d, ovf_d, ferr_d, perr_d;
  logic            par_err;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_bad_q, par_bad_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
    end
  end

  assign par_err = par_bad_q;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    q_d     = q;
    valid_d = valid;
    ovf_d   = ovf;
    ferr_d  = ferr;
    perr_d  = perr;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif

    // Read acknowledge acts on every edge; flag events below take priority over the clear.
    if (rd) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
    end

    if (en) begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (si) state_d = StData;
        end
        StData: begin
          sr_d = {sr_q[N-2:0], si};
          if (cnt_q == CntW'(N - 1)) begin
            cnt_d = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_d = StPar;
`else
            state_d = StStop;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        StPar: begin
          // Even parity: data ones plus parity bit must be even.
          par_bad_d = si ^ (^sr_q);
          state_d   = StStop;
        end
`endif
        StStop: begin
          state_d = StIdle;
          if (si) begin
            ferr_d = 1'b1;
          end else if (par_err) begin
            perr_d = 1'b1;
          end else if (valid && !rd) begin
            ovf_d = 1'b1;
          end else begin
            q_d     = sr_q;
            valid_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sr_q    <= '0;
      q       <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
      ferr    <= 1'b0;
      perr    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q       <= q_d;
      valid   <= valid_d;
      ovf     <= ovf_d;
      ferr    <= ferr_d;
      perr    <= perr_d;
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (N=8); parity cases run when SERIAL_FRAME_RX_PARITY_EN is set.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst, en, si, rd;
  logic [7:0] q;
  logic       valid, busy, ovf, ferr, perr;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_frame_rx #(.N(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .si    (si),
    .rd    (rd),
    .q     (q),
    .valid (valid),
    .busy  (busy),
    .ovf   (ovf),
    .ferr  (ferr),
    .perr  (perr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_step(input logic b, input int gap, input logic r);
    si = b;
    en = 1'b1;
    rd = r;
    tick();
    en = 1'b0;
    rd = 1'b0;
    si = 1'b0;
    repeat (gap) tick();
  endtask

  // Start bit, data MSB first, parity (flipped if asked) when enabled, stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                            input logic rd_on_stop, input logic par_flip);
    bit_step(1'b1, gap, 1'b0);
    for (int i = 7; i >= 0; i--) bit_step(d[i], gap, 1'b0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    bit_step((^d) ^ par_flip, gap, 1'b0);
`else
    if (par_flip) $display("note: parity flip ignored without parity stage");
`endif
    bit_step(stop, gap, rd_on_stop);
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    si  = 1'b0;
    rd  = 1'b0;
    repeat (3) tick();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_flags", {29'h0, ovf, ferr, perr}, 32'h0);
    rst = 1'b0;
    tick();

    // Basic frame A5, en every clock.
    send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
    chk("a5_q", 32'(q), 32'hA5);
    chk("a5_valid", 32'(valid), 32'h1);
    chk("a5_flags", {30'h0, ovf, ferr}, 32'h0);
    chk("a5_busy", 32'(busy), 32'h0);

    // Overrun: 3C dropped.
    send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0);
    chk("ovr_q", 32'(q), 32'hA5);
    chk("ovr_ovf", 32'(ovf), 32'h1);
    chk("ovr_valid", 32'(valid), 32'h1);
    rd_pulse();
    chk("ovr_rd_valid", 32'(valid), 32'h0);
    chk("ovr_rd_ovf", 32'(ovf), 32'h0);

    // Framing error then good frame.
    send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0);
    chk("ferr_ferr", 32'(ferr), 32'h1);
    chk("ferr_valid", 32'(valid), 32'h0);
    chk("ferr_q", 32'(q), 32'hA5);
    chk("ferr_busy", 32'(busy), 32'h0);
    send_frame(8'h01, 1'b0, 0, 1'b0, 1'b0);
    chk("after_ferr_q", 32'(q), 32'h01);
    chk("after_ferr_valid", 32'(valid), 32'h1);
    chk("ferr_sticky", 32'(ferr), 32'h1);
    rd_pulse();
    chk("rd_clr_ferr", 32'(ferr), 32'h0);

    // Prior valid frame, then 81 at 1-of-3 strobes with rd on the commit edge.
    send_frame(8'h22, 1'b0, 0, 1'b0, 1'b0);
    chk("q22", 32'(q), 32'h22);
    send_frame(8'h81, 1'b0, 2, 1'b1, 1'b0);
    chk("slow_q", 32'(q), 32'h81);
    chk("slow_valid", 32'(valid), 32'h1);
    chk("slow_ovf", 32'(ovf), 32'h0);

    // Reset after 4 data bits of 5A (0101).
    bit_step(1'b1, 0, 1'b0);
    bit_step(1'b0, 0, 1'b0);
    bit_step(1'b1, 0, 1'b0);
    bit_step(1'b0, 0, 1'b0);
    bit_step(1'b1, 0, 1'b0);
    chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_q", 32'(q), 32'h00);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    si = 1'b1;
    en = 1'b1;
    tick();
    si = 1'b0;
    rst = 1'b0;
    tick();
    en = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b0);
    chk("q5a", 32'(q), 32'h5A);
    chk("q5a_valid", 32'(valid), 32'h1);
    chk("q5a_flags", {29'h0, ovf, ferr, perr}, 32'h0);

    // Start bit without strobe is ignored.
    si = 1'b1;
    tick();
    si = 1'b0;
    chk("no_en_busy", 32'(busy), 32'h0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    rd_pulse();
    send_frame(8'h07, 1'b0, 0, 1'b0, 1'b1);
    chk("par_bad_perr", 32'(perr), 32'h1);
    chk("par_bad_valid", 32'(valid), 32'h0);
    chk("par_bad_q", 32'(q), 32'h5A);
    send_frame(8'h07, 1'b0, 0, 1'b0, 1'b0);
    chk("par_ok_q", 32'(q), 32'h07);
    chk("par_ok_valid", 32'(valid), 32'h1);
    rd_pulse();
    send_frame(8'h07, 1'b1, 0, 1'b0, 1'b1);
    chk("par_both_flags", {30'h0, ferr, perr}, 32'h2);
`else
    chk("perr_tied", 32'(perr), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
